// File: rtl/tl_line_master.sv
// TileLink UH line master: one 64 B line read (Get + 8 AccessAckData) or write (8 PutFullData + AccessAck).
// Latency: the A channel is valid one cycle after accept, and the response is valid one cycle after the last D beat.
// Backpressure: a_ready stalls the A burst with no bubbles, d_valid is taken only while waiting for D, and rsp is held until rsp_ready.
module tl_line_master #(
  parameter int          DATA_W    = 64,
  parameter int          ADDR_W    = 64,
  parameter int          BEATS     = 8,
  parameter logic [3:0]  SOURCE_ID = 4'd0
) (
  input  logic                     clk,
  input  logic                     rst,
  // command port
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic                     req_write,
  input  logic [ADDR_W-1:0]        req_addr,
  input  logic [DATA_W*BEATS-1:0]  req_wdata,
  // completion port
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic                     rsp_write,
  output logic [DATA_W*BEATS-1:0]  rsp_rdata,
  output logic                     rsp_denied,
  output logic                     rsp_corrupt,
  // TileLink A channel
  output logic [2:0]               a_opcode,
  output logic [2:0]               a_param,
  output logic [2:0]               a_size,
  output logic [3:0]               a_source,
  output logic [ADDR_W-1:0]        a_address,
  output logic [DATA_W/8-1:0]      a_mask,
  output logic [DATA_W-1:0]        a_data,
  output logic                     a_valid,
  input  logic                     a_ready,
  // TileLink D channel
  input  logic [2:0]               d_opcode,
  input  logic [1:0]               d_param,
  input  logic [2:0]               d_size,
  input  logic [1:0]               d_sink,
  input  logic [3:0]               d_source,
  input  logic                     d_denied,
  input  logic [DATA_W-1:0]        d_data,
  input  logic                     d_corrupt,
  input  logic                     d_valid,
  output logic                     d_ready
);

  localparam int LINE_W = DATA_W * BEATS;
  localparam int CNT_W  = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int OFF_W  = $clog2(LINE_W / 8);
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);
  localparam logic [2:0] LINE_SIZE  = 3'(OFF_W);
  localparam logic [2:0] A_GET      = 3'd4;
  localparam logic [2:0] A_PUT_FULL = 3'd0;
  localparam logic [2:0] D_ACK      = 3'd0;
  localparam logic [2:0] D_ACK_DATA = 3'd1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_GET_REQ,
    S_GET_RESP,
    S_PUT_DATA,
    S_PUT_ACK,
    S_DONE
  } state_e;

  state_e                    state_q, state_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic [ADDR_W-OFF_W-1:0]   line_q, line_d;
  logic                      write_q, write_d;
  logic [LINE_W-1:0]         wdata_q, wdata_d;
  logic [LINE_W-1:0]         rdata_q, rdata_d;
  logic                      denied_q, denied_d;
  logic                      corrupt_q, corrupt_d;
  logic                      beat_err;

  // D-channel sideband fields and the in-line byte offset carry no information for this master.
  logic unused_inputs;
  assign unused_inputs = ^{d_param, d_size, d_sink, req_addr[OFF_W-1:0]};

  // State and datapath registers; reset drops any partial transaction on the floor.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      line_q    <= '0;
      write_q   <= 1'b0;
      wdata_q   <= '0;
      rdata_q   <= '0;
      denied_q  <= 1'b0;
      corrupt_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      line_q    <= line_d;
      write_q   <= write_d;
      wdata_q   <= wdata_d;
      rdata_q   <= rdata_d;
      denied_q  <= denied_d;
      corrupt_q <= corrupt_d;
    end
  end

  // Next-state, datapath updates and all outputs, decoded from registered state only.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    line_d    = line_q;
    write_d   = write_q;
    wdata_d   = wdata_q;
    rdata_d   = rdata_q;
    denied_d  = denied_q;
    corrupt_d = corrupt_q;
    beat_err  = 1'b0;

    req_ready   = 1'b0;
    rsp_valid   = 1'b0;
    rsp_write   = 1'b0;
    rsp_rdata   = '0;
    rsp_denied  = 1'b0;
    rsp_corrupt = 1'b0;
    a_opcode    = 3'd0;
    a_param     = 3'd0;
    a_size      = 3'd0;
    a_source    = 4'd0;
    a_address   = '0;
    a_mask      = '0;
    a_data      = '0;
    a_valid     = 1'b0;
    d_ready     = 1'b0;

    case (state_q)
      S_IDLE: begin
        // Held low while rst is asserted so nothing looks acceptable during reset.
        req_ready = !rst;
        if (req_valid) begin
          line_d    = req_addr[ADDR_W-1:OFF_W];
          write_d   = req_write;
          wdata_d   = req_wdata;
          rdata_d   = '0;
          cnt_d     = '0;
          denied_d  = 1'b0;
          corrupt_d = 1'b0;
          state_d   = req_write ? S_PUT_DATA : S_GET_REQ;
        end
      end

      S_GET_REQ: begin
        a_valid  = 1'b1;
        a_opcode = A_GET;
        if (a_ready) begin
          state_d = S_GET_RESP;
        end
      end

      S_GET_RESP: begin
        d_ready = 1'b1;
        if (d_valid) begin
          // A malformed beat is flagged as corrupt but still fills its slot and counts.
          beat_err  = d_corrupt || (d_opcode != D_ACK_DATA) || (d_source != SOURCE_ID);
          denied_d  = denied_q | d_denied;
          corrupt_d = corrupt_q | beat_err;
          rdata_d[int'(cnt_q)*DATA_W +: DATA_W] = d_data;
          if (cnt_q == LAST_BEAT) begin
            cnt_d   = '0;
            state_d = S_DONE;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end

      S_PUT_DATA: begin
        a_valid  = 1'b1;
        a_opcode = A_PUT_FULL;
        a_data   = wdata_q[int'(cnt_q)*DATA_W +: DATA_W];
        if (a_ready) begin
          if (cnt_q == LAST_BEAT) begin
            cnt_d   = '0;
            state_d = S_PUT_ACK;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end

      S_PUT_ACK: begin
        d_ready = 1'b1;
        if (d_valid) begin
          beat_err  = d_corrupt || (d_opcode != D_ACK) || (d_source != SOURCE_ID);
          denied_d  = denied_q | d_denied;
          corrupt_d = corrupt_q | beat_err;
          state_d   = S_DONE;
        end
      end

      S_DONE: begin
        rsp_valid   = 1'b1;
        rsp_write   = write_q;
        rsp_rdata   = rdata_q;
        rsp_denied  = denied_q;
        rsp_corrupt = corrupt_q;
        if (rsp_ready) begin
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Request attributes that are constant for the whole burst.
    if (a_valid) begin
      a_size    = LINE_SIZE;
      a_source  = SOURCE_ID;
      a_mask    = '1;
      a_address = {line_q, {OFF_W{1'b0}}};
    end
  end

endmodule

// File: tb/tb_tl_line_master.sv
// Randomized bench for tl_line_master with a line-level memory model and a TileLink responder.
// Each transaction is checked beat by beat on A, and the final completion is compared against the model.
module tb_tl_line_master;

  typedef logic [511:0] w_t;

  logic         clk = 1'b0;
  logic         rst;
  logic         req_valid, req_ready, req_write;
  logic [63:0]  req_addr;
  logic [511:0] req_wdata;
  logic         rsp_valid, rsp_ready, rsp_write;
  logic [511:0] rsp_rdata;
  logic         rsp_denied, rsp_corrupt;
  logic [2:0]   a_opcode, a_param, a_size;
  logic [3:0]   a_source;
  logic [63:0]  a_address;
  logic [7:0]   a_mask;
  logic [63:0]  a_data;
  logic         a_valid, a_ready;
  logic [2:0]   d_opcode;
  logic [1:0]   d_param;
  logic [2:0]   d_size;
  logic [1:0]   d_sink;
  logic [3:0]   d_source;
  logic         d_denied;
  logic [63:0]  d_data;
  logic         d_corrupt, d_valid, d_ready;

  int n_chk = 0;
  int n_err = 0;

  // Expected memory contents (from commands) and responder RAM (from observed A beats).
  logic [63:0] mdl [longint];
  logic [63:0] ram [longint];

  tl_line_master dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write),
    .rsp_rdata(rsp_rdata), .rsp_denied(rsp_denied), .rsp_corrupt(rsp_corrupt),
    .a_opcode(a_opcode), .a_param(a_param), .a_size(a_size), .a_source(a_source),
    .a_address(a_address), .a_mask(a_mask), .a_data(a_data),
    .a_valid(a_valid), .a_ready(a_ready),
    .d_opcode(d_opcode), .d_param(d_param), .d_size(d_size), .d_sink(d_sink),
    .d_source(d_source), .d_denied(d_denied), .d_data(d_data),
    .d_corrupt(d_corrupt), .d_valid(d_valid), .d_ready(d_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input w_t obs, input w_t exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Unwritten memory holds its own word index.
  function automatic logic [63:0] mdl_rd(input longint idx);
    return mdl.exists(idx) ? mdl[idx] : 64'(idx);
  endfunction

  function automatic logic [63:0] ram_rd(input longint idx);
    return ram.exists(idx) ? ram[idx] : 64'(idx);
  endfunction

  function automatic w_t rand_line();
    w_t v;
    for (int i = 0; i < 16; i++) v[i*32 +: 32] = $urandom();
    return v;
  endfunction

  task automatic chk_all_zero(input string tag);
    chk({tag, "_rdata"}, rsp_rdata, '0);
    chk({tag, "_ctl"}, w_t'({req_ready, rsp_valid, rsp_write, rsp_denied, rsp_corrupt,
                            a_valid, d_ready, a_opcode, a_param, a_size, a_source, a_mask}), '0);
    chk({tag, "_a_bus"}, w_t'({a_address, a_data}), '0);
  endtask

  // One full command. Called and returning on a negedge.
  // *_b: beat index carrying that D-channel fault (-1 none); stall_b: Put beat held off
  // for 3 cycles; rst_after: read beat after which reset is pulsed (-1 none).
  task automatic do_txn(input bit wr, input logic [63:0] addr, input w_t wd,
                        input int den_b, input int cor_b, input int src_b, input int op_b,
                        input int stall_b, input int rsp_hold, input int rst_after);
    longint      base;
    int          nb, nd, k, guard, stall_n;
    logic [63:0] exp_adr, obs_dat;
    logic        obs_vld, exp_den, exp_cor;
    w_t          exp_rd;

    base    = longint'(addr >> 6) * 8;
    exp_adr = {addr[63:6], 6'b0};

    req_valid = 1'b1; req_write = wr; req_addr = addr; req_wdata = wd;
    chk("req_ready_idle", w_t'(req_ready), w_t'(1));
    @(posedge clk); @(negedge clk);
    req_valid = 1'b0; req_write = ~wr; req_addr = {$urandom(), $urandom()}; req_wdata = rand_line();
    chk("req_ready_busy", w_t'(req_ready), w_t'(0));

    nb = wr ? 8 : 1;
    k = 0; guard = 0; stall_n = 0;
    while (k < nb && guard < 200) begin
      guard++;
      if (wr && k == stall_b && stall_n < 3) begin
        a_ready = 1'b0;
        stall_n++;
      end else begin
        a_ready = ($urandom_range(0, 3) != 0);
      end
      d_valid = ($urandom_range(0, 4) == 0);
      d_data  = {$urandom(), $urandom()};
      if (d_valid) chk("d_ready_during_a", w_t'(d_ready), w_t'(0));
      chk("a_valid", w_t'(a_valid), w_t'(1));
      chk("a_opcode", w_t'(a_opcode), wr ? w_t'(0) : w_t'(4));
      chk("a_address", w_t'(a_address), w_t'(exp_adr));
      chk("a_fields", w_t'({a_size, a_mask, a_param, a_source}), w_t'({3'd6, 8'hFF, 3'd0, 4'd0}));
      chk("a_data", w_t'(a_data), wr ? w_t'(wd[k*64 +: 64]) : w_t'(0));
      obs_dat = a_data;
      obs_vld = a_valid;
      @(posedge clk);
      if (a_ready) begin
        if (wr && obs_vld) ram[base + longint'(k)] = obs_dat;
        k++;
      end
      @(negedge clk);
    end
    if (guard >= 200) chk("a_phase_timeout", w_t'(1), w_t'(0));
    a_ready = 1'b0; d_valid = 1'b0;
    chk("a_valid_after_burst", w_t'(a_valid), w_t'(0));

    nd = wr ? 1 : 8;
    exp_den = 1'b0; exp_cor = 1'b0;
    for (int i = 0; i < nd; i++) begin
      repeat ($urandom_range(0, 2)) begin
        chk("d_ready_idle_wait", w_t'(d_ready), w_t'(1));
        @(negedge clk);
      end
      d_valid   = 1'b1;
      d_opcode  = wr ? ((i == op_b) ? 3'd1 : 3'd0) : ((i == op_b) ? 3'd0 : 3'd1);
      d_source  = (i == src_b) ? 4'hF : 4'h0;
      d_denied  = (i == den_b);
      d_corrupt = (i == cor_b);
      d_data    = wr ? {$urandom(), $urandom()} : ram_rd(base + longint'(i));
      d_param   = 2'($urandom()); d_size = 3'($urandom()); d_sink = 2'($urandom());
      exp_den   = exp_den | (i == den_b);
      exp_cor   = exp_cor | (i == cor_b) | (i == src_b) | (i == op_b);
      chk("d_ready", w_t'(d_ready), w_t'(1));
      @(posedge clk); @(negedge clk);
      d_valid = 1'b0; d_denied = 1'b0; d_corrupt = 1'b0; d_source = 4'h0;
      if (i == rst_after) begin
        rst = 1'b1;
        @(posedge clk); @(negedge clk);
        chk_all_zero("mid_rst");
        rst = 1'b0;
        @(posedge clk); @(negedge clk);
        chk("req_ready_after_rst", w_t'(req_ready), w_t'(1));
        chk("rsp_valid_after_rst", w_t'(rsp_valid), w_t'(0));
        return;
      end
    end

    exp_rd = '0;
    if (wr) begin
      for (int j = 0; j < 8; j++) mdl[base + longint'(j)] = wd[j*64 +: 64];
    end else begin
      for (int j = 0; j < 8; j++) exp_rd[j*64 +: 64] = mdl_rd(base + longint'(j));
    end

    guard = 0;
    while (!rsp_valid && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    chk("rsp_valid", w_t'(rsp_valid), w_t'(1));
    for (int h = 0; h <= rsp_hold; h++) begin
      rsp_ready = (h == rsp_hold);
      chk("rsp_valid_held", w_t'(rsp_valid), w_t'(1));
      chk("rsp_write", w_t'(rsp_write), w_t'(wr));
      chk("rsp_rdata", rsp_rdata, exp_rd);
      chk("rsp_denied", w_t'(rsp_denied), w_t'(exp_den));
      chk("rsp_corrupt", w_t'(rsp_corrupt), w_t'(exp_cor));
      chk("done_quiet", w_t'({req_ready, a_valid, d_ready}), w_t'(0));
      @(posedge clk); @(negedge clk);
    end
    rsp_ready = 1'b0;
    chk("rsp_valid_drop", w_t'(rsp_valid), w_t'(0));
    chk("req_ready_back", w_t'(req_ready), w_t'(1));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    w_t   wd;
    bit   wr;
    int   nd;
    logic [63:0] addr;

    rst = 1'b1;
    req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0;
    rsp_ready = 1'b0; a_ready = 1'b0;
    d_opcode = '0; d_param = '0; d_size = '0; d_sink = '0; d_source = '0;
    d_denied = 1'b0; d_data = '0; d_corrupt = 1'b0; d_valid = 1'b0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_all_zero("reset");
    rst = 1'b0;
    @(negedge clk);
    chk("req_ready_after_reset", w_t'(req_ready), w_t'(1));

    // Clean read of line 0x40: identity memory gives words 8..15.
    do_txn(1'b0, 64'h40, '0, -1, -1, -1, -1, -1, 0, -1);

    // Write A0..A7 to 0x80 and read it back.
    for (int i = 0; i < 8; i++) wd[i*64 +: 64] = 64'hA0 + 64'(i);
    do_txn(1'b1, 64'h80, wd, -1, -1, -1, -1, -1, 0, -1);
    do_txn(1'b0, 64'h80, '0, -1, -1, -1, -1, -1, 0, -1);

    // Reset after beat 4 of a read, then a clean read of the same line.
    do_txn(1'b0, 64'h40, '0, -1, -1, -1, -1, -1, 0, 4);
    do_txn(1'b0, 64'h40, '0, -1, -1, -1, -1, -1, 0, -1);

    // Misaligned address with a 3-cycle a_ready stall mid-burst.
    do_txn(1'b1, 64'h47, rand_line(), -1, -1, -1, -1, 3, 0, -1);

    // Completion held for 5 cycles.
    do_txn(1'b0, 64'hC0, '0, -1, -1, -1, -1, -1, 5, -1);

    // Denied beat 3, then a bad source on the next transaction.
    do_txn(1'b0, 64'h100, '0, 3, -1, -1, -1, -1, 0, -1);
    do_txn(1'b0, 64'h100, '0, -1, -1, 2, -1, -1, 0, -1);

    // Opcode mismatch on a write ack and a corrupt read beat.
    do_txn(1'b1, 64'h140, rand_line(), -1, -1, -1, 0, -1, 0, -1);
    do_txn(1'b0, 64'h140, '0, -1, 7, -1, -1, -1, 0, -1);

    for (int t = 0; t < 60; t++) begin
      wr   = 1'($urandom_range(0, 1));
      nd   = wr ? 1 : 8;
      addr = (64'($urandom_range(0, 15)) << 6) | 64'($urandom_range(0, 63));
      do_txn(wr, addr, rand_line(),
             ($urandom_range(0, 3) == 0) ? $urandom_range(0, nd - 1) : -1,
             ($urandom_range(0, 3) == 0) ? $urandom_range(0, nd - 1) : -1,
             ($urandom_range(0, 5) == 0) ? $urandom_range(0, nd - 1) : -1,
             ($urandom_range(0, 5) == 0) ? $urandom_range(0, nd - 1) : -1,
             wr ? (($urandom_range(0, 1) == 0) ? $urandom_range(0, 7) : -1) : -1,
             $urandom_range(0, 3),
             (!wr && $urandom_range(0, 9) == 0) ? $urandom_range(0, 6) : -1);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
